// File: rtl/lockin_pkg.sv
// Shared definitions for the lock-in magnitude stage.
package lockin_pkg;

  localparam int Q_IN_DEFAULT  = 32;
  localparam int Q_MAG_DEFAULT = Q_IN_DEFAULT + 1;
  // Cycles from the edge that samples data_in_valid to data_out_valid.
  localparam int MAG_LATENCY   = Q_IN_DEFAULT + 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABS,
    ST_SQUARE,
    ST_SUM,
    ST_SQRT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/lockin_magnitude_isqrt_seq.sv
// Sequential restoring integer square root: one root bit per cycle,
// consuming the radicand two bits per cycle, MSB pair first.
module isqrt_seq #(
  parameter int W = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2*W-1:0]   radicand,
  output logic             done,
  output logic [W-1:0]     root
);

  localparam int IW = $clog2(W);

  logic [2*W-1:0] rad;
  logic [W-1:0]   root_q;
  // The remainder never exceeds 2*root, so W+1 bits hold it.
  logic [W:0]     rem;
  logic [W+2:0]   rem_sh;
  logic [W+2:0]   trial;
  logic           ge;
  logic [IW-1:0]  iter;
  logic           running;

  assign rem_sh = {rem, rad[2*W-1 -: 2]};
  assign trial  = {1'b0, root_q, 2'b01};
  assign ge     = (rem_sh >= trial);
  assign done   = running && (iter == IW'(W - 1));
  assign root   = root_q;

  // Load on start, then shift in one root bit per cycle until done.
  always_ff @(posedge clk) begin
    if (reset) begin
      rad     <= '0;
      root_q  <= '0;
      rem     <= '0;
      iter    <= '0;
      running <= 1'b0;
    end else if (start) begin
      rad     <= radicand;
      root_q  <= '0;
      rem     <= '0;
      iter    <= '0;
      running <= 1'b1;
    end else if (running) begin
      rad     <= {rad[2*W-3:0], 2'b00};
      rem     <= ge ? (W+1)'(rem_sh - trial) : rem_sh[W:0];
      root_q  <= {root_q[W-2:0], ge};
      iter    <= iter + IW'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/lockin_magnitude.sv
// Lock-in magnitude stage: floor(sqrt(I^2+Q^2)) with aligned I/Q copies,
// a one-deep pending slot and a sticky overrun flag.
import lockin_pkg::*;

module lockin_magnitude #(
  parameter  int Q_in  = Q_IN_DEFAULT,
  localparam int Q_mag = Q_in + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Q_in-1:0]  data_in_fase,
  input  logic [Q_in-1:0]  data_in_cuad,
  input  logic             data_in_valid,
  input  logic             clear_overrun,
  output logic [Q_mag-1:0] mag_out,
  output logic [Q_in-1:0]  fase_out,
  output logic [Q_in-1:0]  cuad_out,
  output logic             data_out_valid,
  output logic             busy,
  output logic             overrun
);

  state_t state, state_nx;

  logic [Q_in-1:0]    cur_fase, cur_cuad;
  logic [Q_in-1:0]    pend_fase, pend_cuad;
  logic               pend_valid;
  logic [Q_in-1:0]    abs_a, abs_b;
  logic [2*Q_in-1:0]  sq_a, sq_b;
  logic [2*Q_mag-1:0] radicand;
  logic               sq_start, sq_done;
  logic [Q_mag-1:0]   sq_root;
  logic               consume_pend, load_live, pend_wr, overrun_set;

  // Any live strobe not taken directly in IDLE lands in the pending slot.
  assign pend_wr     = data_in_valid && !load_live;
  assign overrun_set = pend_wr && pend_valid && !consume_pend;
  assign radicand    = {2'b00, sq_a} + {2'b00, sq_b};
  assign busy        = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state; DONE chains straight into a pending sample so a queued
  // pair follows the previous result by exactly one pipeline period.
  always_comb begin
    state_nx     = state;
    consume_pend = 1'b0;
    load_live    = 1'b0;
    sq_start     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_valid) begin
          consume_pend = 1'b1;
          state_nx     = ST_ABS;
        end else if (data_in_valid) begin
          load_live = 1'b1;
          state_nx  = ST_ABS;
        end
      end
      ST_ABS:    state_nx = ST_SQUARE;
      ST_SQUARE: state_nx = ST_SUM;
      ST_SUM: begin
        sq_start = 1'b1;
        state_nx = ST_SQRT;
      end
      ST_SQRT:   if (sq_done) state_nx = ST_DONE;
      ST_DONE: begin
        if (pend_valid) begin
          consume_pend = 1'b1;
          state_nx     = ST_ABS;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Capture the working pair and maintain the pending slot and overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_fase   <= '0;
      cur_cuad   <= '0;
      pend_fase  <= '0;
      pend_cuad  <= '0;
      pend_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (consume_pend) begin
        cur_fase <= pend_fase;
        cur_cuad <= pend_cuad;
      end else if (load_live) begin
        cur_fase <= data_in_fase;
        cur_cuad <= data_in_cuad;
      end
      if (pend_wr) begin
        pend_fase <= data_in_fase;
        pend_cuad <= data_in_cuad;
      end
      if (consume_pend)  pend_valid <= pend_wr;
      else if (pend_wr)  pend_valid <= 1'b1;
      if (overrun_set)        overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

  // Abs and square stages; -2^(Q_in-1) wraps to 2^(Q_in-1) as unsigned.
  always_ff @(posedge clk) begin
    if (reset) begin
      abs_a <= '0;
      abs_b <= '0;
      sq_a  <= '0;
      sq_b  <= '0;
    end else begin
      if (state == ST_ABS) begin
        abs_a <= cur_fase[Q_in-1] ? (~cur_fase) + Q_in'(1) : cur_fase;
        abs_b <= cur_cuad[Q_in-1] ? (~cur_cuad) + Q_in'(1) : cur_cuad;
      end
      if (state == ST_SQUARE) begin
        sq_a <= (2*Q_in)'(abs_a) * (2*Q_in)'(abs_a);
        sq_b <= (2*Q_in)'(abs_b) * (2*Q_in)'(abs_b);
      end
    end
  end

  isqrt_seq #(.W(Q_mag)) u_isqrt (
    .clk      (clk),
    .reset    (reset),
    .start    (sq_start),
    .radicand (radicand),
    .done     (sq_done),
    .root     (sq_root)
  );

  // Output registers: updated only in DONE, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      mag_out        <= '0;
      fase_out       <= '0;
      cuad_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= (state == ST_DONE);
      if (state == ST_DONE) begin
        mag_out  <= sq_root;
        fase_out <= cur_fase;
        cuad_out <= cur_cuad;
      end
    end
  end

endmodule

// File: tb/tb_lockin_magnitude.sv
// Scoreboard bench for lockin_magnitude (Q_in = 32).
module tb_lockin_magnitude;

  typedef struct packed {
    logic [32:0] mag;
    logic [31:0] f;
    logic [31:0] c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in_fase = '0;
  logic [31:0] data_in_cuad = '0;
  logic        data_in_valid = 1'b0;
  logic        clear_overrun = 1'b0;
  logic [32:0] mag_out;
  logic [31:0] fase_out, cuad_out;
  logic        data_out_valid, busy, overrun;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   valid_count = 0;
  int   last_vcyc = 0;
  logic vprev = 1'b0;

  lockin_magnitude #(.Q_in(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in_fase   (data_in_fase),
    .data_in_cuad   (data_in_cuad),
    .data_in_valid  (data_in_valid),
    .clear_overrun  (clear_overrun),
    .mag_out        (mag_out),
    .fase_out       (fase_out),
    .cuad_out       (cuad_out),
    .data_out_valid (data_out_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference: bitwise search for the largest r with r*r <= n.
  function automatic exp_t expect_of(input logic signed [31:0] i, input logic signed [31:0] q);
    logic signed [67:0] si, sq;
    logic [67:0] ai, aq, n, r, c;
    exp_t e;
    si = 68'(i);
    sq = 68'(q);
    ai = (si < 0) ? 68'(-si) : 68'(si);
    aq = (sq < 0) ? 68'(-sq) : 68'(sq);
    n  = ai * ai + aq * aq;
    r  = '0;
    for (int b = 32; b >= 0; b--) begin
      c = r | (68'd1 << b);
      if (c * c <= n) r = c;
    end
    e.mag = r[32:0];
    e.f   = i;
    e.c   = q;
    return e;
  endfunction

  // Output monitor: pop the scoreboard on every result strobe.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (data_out_valid === 1'b1) begin
        valid_count++;
        last_vcyc = cyc;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: result mag=%0d with no expected entry", mag_out);
        end else begin
          e = sb.pop_front();
          if ({mag_out, fase_out, cuad_out} !== e) begin
            n_fail++;
            $display("FAIL result: got mag=%0d fase=%0d cuad=%0d, expected mag=%0d fase=%0d cuad=%0d",
                     mag_out, $signed(fase_out), $signed(cuad_out), e.mag, $signed(e.f), $signed(e.c));
          end
        end
        n_checks++;
        if (vprev === 1'b1) begin
          n_fail++;
          $display("FAIL valid_width: data_out_valid high 2+ cycles, expected 1");
        end
      end
      vprev = data_out_valid;
    end
  end

  task automatic send(input logic signed [31:0] i, input logic signed [31:0] q,
                      input bit push, output int edge_cyc);
    @(posedge clk); #1;
    data_in_fase  = i;
    data_in_cuad  = q;
    data_in_valid = 1'b1;
    if (push) sb.push_back(expect_of(i, q));
    @(posedge clk); #1;
    edge_cyc      = cyc;
    data_in_valid = 1'b0;
  endtask

  task automatic wait_result(input int prev, input string tag, output int vcyc);
    int k = 0;
    while (valid_count == prev && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    n_checks++;
    if (valid_count == prev) begin
      n_fail++;
      $display("FAIL %s_timeout: no data_out_valid in 300 cycles, expected one", tag);
    end
    vcyc = last_vcyc;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({mag_out, fase_out, cuad_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got mag=%0d fase=%0d cuad=%0d, expected 0", mag_out, fase_out, cuad_out);
    end
    n_checks++;
    if ({data_out_valid, busy, overrun} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/busy/overrun=%b, expected 000", {data_out_valid, busy, overrun});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int e, v, p;
    p = valid_count;
    send(32'sd3, 32'sd4, 1'b1, e);
    wait_result(p, "basic", v);
    n_checks++;
    if (v - e !== 37) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles, expected 37", v - e);
    end
    n_checks++;
    if (mag_out !== 33'd5) begin
      n_fail++;
      $display("FAIL basic_mag: got %0d, expected 5", mag_out);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({data_out_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_after: got valid/busy=%b, expected 00", {data_out_valid, busy});
    end
  endtask

  task automatic test_signs();
    logic signed [31:0] ti [3] = '{-32'sd3, 32'sd0, 32'sd1};
    logic signed [31:0] tq [3] = '{-32'sd4, 32'sd0, 32'sd1};
    logic [32:0]        tm [3] = '{33'd5, 33'd0, 33'd1};
    int e, v, p;
    for (int k = 0; k < 3; k++) begin
      p = valid_count;
      send(ti[k], tq[k], 1'b1, e);
      wait_result(p, "signs", v);
      n_checks++;
      if (mag_out !== tm[k]) begin
        n_fail++;
        $display("FAIL signs_mag%0d: got %0d, expected %0d", k, mag_out, tm[k]);
      end
      repeat (12) @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL signs_busy%0d: got %b, expected 0", k, busy);
      end
    end
  endtask

  task automatic test_extremes();
    int e, v, p;
    p = valid_count;
    send(32'sh8000_0000, 32'sh8000_0000, 1'b1, e);
    wait_result(p, "ext_min", v);
    n_checks++;
    if (mag_out !== 33'd3037000499) begin
      n_fail++;
      $display("FAIL ext_min_mag: got %0d, expected 3037000499", mag_out);
    end
    p = valid_count;
    send(32'sh7fff_ffff, 32'sd0, 1'b1, e);
    wait_result(p, "ext_max", v);
    n_checks++;
    if (mag_out !== 33'd2147483647) begin
      n_fail++;
      $display("FAIL ext_max_mag: got %0d, expected 2147483647", mag_out);
    end
  endtask

  task automatic test_random();
    int e, v, p;
    for (int k = 0; k < 8; k++) begin
      p = valid_count;
      send($urandom, $urandom, 1'b1, e);
      wait_result(p, "random", v);
      n_checks++;
      if (v - e !== 37) begin
        n_fail++;
        $display("FAIL random_latency%0d: got %0d, expected 37", k, v - e);
      end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int v1, v2, p;
    p = valid_count;
    @(posedge clk); #1;
    data_in_fase = 32'sd6; data_in_cuad = 32'sd8; data_in_valid = 1'b1;
    sb.push_back(expect_of(32'sd6, 32'sd8));
    @(posedge clk); #1;
    data_in_fase = 32'sd5; data_in_cuad = 32'sd12;
    @(posedge clk); #1;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_overrun_early: got %b, expected 0", overrun);
    end
    data_in_fase = 32'sd8; data_in_cuad = 32'sd15;
    sb.push_back(expect_of(32'sd8, 32'sd15));
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_overrun: got %b, expected 1", overrun);
    end
    wait_result(p, "b2b_first", v1);
    n_checks++;
    if (mag_out !== 33'd10) begin
      n_fail++;
      $display("FAIL b2b_mag1: got %0d, expected 10", mag_out);
    end
    wait_result(p + 1, "b2b_second", v2);
    n_checks++;
    if (mag_out !== 33'd17) begin
      n_fail++;
      $display("FAIL b2b_mag2: got %0d, expected 17", mag_out);
    end
    n_checks++;
    if (v2 - v1 !== 37) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles, expected 37", v2 - v1);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_clear_overrun();
    int v, p;
    @(posedge clk); #1;
    clear_overrun = 1'b1;
    @(posedge clk); #1;
    clear_overrun = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_overrun: got %b, expected 0", overrun);
    end
    p = valid_count;
    @(posedge clk); #1;
    data_in_fase = 32'sd9; data_in_cuad = 32'sd12; data_in_valid = 1'b1;
    sb.push_back(expect_of(32'sd9, 32'sd12));
    @(posedge clk); #1;
    data_in_fase = 32'sd1; data_in_cuad = 32'sd2;
    @(posedge clk); #1;
    data_in_fase = -32'sd12; data_in_cuad = 32'sd16; clear_overrun = 1'b1;
    sb.push_back(expect_of(-32'sd12, 32'sd16));
    @(posedge clk); #1;
    data_in_valid = 1'b0; clear_overrun = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_set_wins: got %b, expected 1", overrun);
    end
    wait_result(p, "clr_first", v);
    wait_result(p + 1, "clr_second", v);
    n_checks++;
    if (mag_out !== 33'd20) begin
      n_fail++;
      $display("FAIL clr_mag: got %0d, expected 20", mag_out);
    end
    @(posedge clk); #1;
    clear_overrun = 1'b1;
    @(posedge clk); #1;
    clear_overrun = 1'b0;
  endtask

  task automatic test_reset_mid();
    int e, v, p;
    p = valid_count;
    send(32'sd7, 32'sd24, 1'b0, e);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if ({mag_out, fase_out, cuad_out, data_out_valid, busy, overrun} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got mag=%0d fase=%0d cuad=%0d v/b/o=%b, expected all 0",
               mag_out, fase_out, cuad_out, {data_out_valid, busy, overrun});
    end
    repeat (50) @(posedge clk);
    #1;
    n_checks++;
    if (valid_count !== p) begin
      n_fail++;
      $display("FAIL mid_no_valid: got %0d results, expected 0", valid_count - p);
    end
    send(32'sd3, 32'sd4, 1'b1, e);
    wait_result(p, "mid_after", v);
    n_checks++;
    if (v - e !== 37 || mag_out !== 33'd5) begin
      n_fail++;
      $display("FAIL mid_after: got latency=%0d mag=%0d, expected 37 and 5", v - e, mag_out);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    test_reset();
    test_basic();
    test_signs();
    test_extremes();
    test_random();
    test_back_to_back();
    test_clear_overrun();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lockin_magnitude.md
Name: lockin_magnitude

Overview:
- Downstream stage of the lock-in state machine; consumes each in-phase/quadrature accumulator pair and its valid strobe.
- Produces floor(sqrt(I^2+Q^2)) with a sequential restoring integer square root (one result bit per cycle).
- Forwards aligned copies of I/Q to the SSVEP decision/readout logic.
- A one-deep pending register absorbs a sample arriving while busy.

Parameters:
- Q_in, 32, width of signed I/Q inputs (matches lock-in Q_out).
- Q_mag, Q_in+1, magnitude output width; fixed to Q_in+1 and not overridable independently.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- data_in_fase  in  Q_in  signed in-phase accumulator.
- data_in_cuad  in  Q_in  signed quadrature accumulator.
- data_in_valid  in  1  one-cycle strobe qualifying the I/Q pair.
- clear_overrun  in  1  synchronous clear of overrun flag.
- mag_out  out  Q_mag  unsigned magnitude.
- fase_out  out  Q_in  I value the magnitude was computed from.
- cuad_out  out  Q_in  Q value the magnitude was computed from.
- data_out_valid  out  1  one-cycle strobe for mag_out/fase_out/cuad_out.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; set when a pending sample is overwritten.

Behaviour:
- Reset (sync, active-high): state=IDLE; mag_out, fase_out, cuad_out, data_out_valid, overrun, pending_valid all 0; busy=0.
- IDLE: if pending_valid, load pending pair and clear pending_valid; else if data_in_valid, load the live pair. Either load goes to ABS.
  - If pending and a live sample occur in the same IDLE cycle, the pending pair is used and the live pair becomes pending.
- ABS: compute a=|I|, b=|Q| as Q_in-bit unsigned. -2^(Q_in-1) maps to 2^(Q_in-1); no saturation.
- SQUARE: a^2 and b^2, each 2*Q_in bits unsigned.
- SUM: radicand = a^2+b^2 (2*Q_in+1 bits, zero-extended to 2*Q_in+2); init root=0, remainder=0, iter=0.
- SQRT: restoring algorithm, one bit per cycle, iterations 0..Q_in (Q_in+1 cycles); consume radicand two bits per cycle, MSB pair first.
- DONE: register mag_out=root, fase_out/cuad_out=captured pair; pulse data_out_valid for exactly one cycle; go to IDLE.
- Outputs hold their values until the next DONE.
- Latency: data_out_valid is high exactly Q_in+5 cycles after the edge that sampled data_in_valid (no pending contention). With pending, the next result follows Q_in+5 cycles after the previous result.
- Throughput: one result per Q_in+5 cycles.
- Busy input handling: data_in_valid while busy writes the pending register.
  - If pending_valid is already 1, the old pending pair is overwritten and overrun is set.
  - Live data is never stalled; there is no ready signal.
- overrun: cleared by reset or clear_overrun. If set and clear occur in the same cycle, set wins.
- Rounding: floor. Result is exact for perfect squares.
- No reset mid-operation recovery beyond reset: the in-flight computation is abandoned and no data_out_valid is produced.

Decomposition:
- Package lockin_pkg: state encoding (IDLE, ABS, SQUARE, SUM, SQRT, DONE), default Q_in, the derived Q_mag = Q_in+1, and the latency constant MAG_LATENCY = Q_in+5.
- Sub-module isqrt_seq (start, radicand, done, root) for the iterative square root.
- The top level owns abs/square/sum, the pending register, overrun and output registers.

Test Plan:
- Q_in=32. Inputs (3,4) -> mag_out=5, fase_out=3, cuad_out=4; data_out_valid high exactly 37 cycles after the in_valid edge, one cycle wide.
- Inputs (-3,-4), then (0,0), then (1,1), spaced 50 cycles apart -> mag_out = 5, 0, 1 respectively; busy low between results.
- Inputs (-2^31,-2^31) -> mag_out=3037000499 (0xB504F333). Inputs (2^31-1,0) -> mag_out=2147483647.
- Three strobes on consecutive cycles (A=(6,8), B=(5,12), C=(8,15)) -> results 10 then 17 (B dropped); overrun=1 from the cycle after C; second result arrives 37 cycles after the first.
- After overrun=1, pulse clear_overrun with no data_in_valid -> overrun=0 next cycle. Pulse clear_overrun in the same cycle as an overwriting strobe -> overrun stays 1.
- Assert reset 10 cycles into a computation -> all outputs 0 the following cycle; no data_out_valid. A new (3,4) after reset yields 5 with nominal latency.
